// File: rtl/pwm_ramp_ctrl.sv
// Purpose : ramps the PWM compare value toward a requested target, one step per PWM period.
// Latency : new compare value one cycle after the period-start strobe; done_o rises with the final value.
// Backpr. : cfg_ready_o is high only in IDLE; requests arriving during a ramp are dropped, not queued.
// Optional: define PWM_RAMP_PRESCALE_EN to add prescale_i (step only every prescale_i+1 strobes).
module pwm_ramp_ctrl #(
    parameter int COUNTER_WIDTH = 8,
    parameter int RESET_CMP     = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     period_start_i,
    input  logic                     cfg_valid_i,
    output logic                     cfg_ready_o,
    input  logic [COUNTER_WIDTH-1:0] cfg_target_i,
    input  logic [COUNTER_WIDTH-1:0] cfg_step_i,
    input  logic                     abort_i,
`ifdef PWM_RAMP_PRESCALE_EN
    input  logic [7:0]               prescale_i,
`endif
    output logic [COUNTER_WIDTH-1:0] cmp_value_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam logic [COUNTER_WIDTH-1:0] LP_RESET_CMP = COUNTER_WIDTH'(RESET_CMP);
    localparam logic [COUNTER_WIDTH-1:0] LP_ONE       = COUNTER_WIDTH'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [COUNTER_WIDTH-1:0] r_cmp;
    logic [COUNTER_WIDTH-1:0] r_target;
    logic [COUNTER_WIDTH-1:0] r_step;
    logic                     r_done;
    logic [COUNTER_WIDTH-1:0] w_cmp_nxt;
    logic [COUNTER_WIDTH-1:0] w_target_nxt;
    logic [COUNTER_WIDTH-1:0] w_step_nxt;
    logic                     w_done_nxt;
    logic [COUNTER_WIDTH-1:0] w_diff_up;
    logic [COUNTER_WIDTH-1:0] w_diff_dn;
    logic [COUNTER_WIDTH-1:0] w_stepped;
    logic                     w_apply;

`ifdef PWM_RAMP_PRESCALE_EN
    logic [7:0] r_pcnt;
    logic [7:0] w_pcnt_nxt;

    // A strobe only counts as a step once enough strobes have been skipped; >= keeps a
    // mid-ramp reduction of prescale_i from stranding the counter above the new limit.
    assign w_apply = (r_pcnt >= prescale_i);
`else
    assign w_apply = 1'b1;
`endif

    // Candidate next compare value: distances are taken first so the step saturates at the target.
    always_comb begin
        w_diff_up = r_target - r_cmp;
        w_diff_dn = r_cmp - r_target;
        w_stepped = r_cmp;
        if (r_cmp < r_target) begin
            w_stepped = (w_diff_up <= r_step) ? r_target : r_cmp + r_step;
        end else if (r_cmp > r_target) begin
            w_stepped = (w_diff_dn <= r_step) ? r_target : r_cmp - r_step;
        end
    end

    // Next-state and next-datapath decode; abort outranks a coincident strobe.
    always_comb begin
        w_state_nxt  = r_state;
        w_cmp_nxt    = r_cmp;
        w_target_nxt = r_target;
        w_step_nxt   = r_step;
        w_done_nxt   = 1'b0;
`ifdef PWM_RAMP_PRESCALE_EN
        w_pcnt_nxt   = r_pcnt;
`endif
        case (r_state)
            IDLE: begin
                if (cfg_valid_i) begin
                    w_state_nxt  = RAMP;
                    w_target_nxt = cfg_target_i;
                    w_step_nxt   = (cfg_step_i == '0) ? LP_ONE : cfg_step_i;
`ifdef PWM_RAMP_PRESCALE_EN
                    w_pcnt_nxt   = '0;
`endif
                end
            end
            RAMP: begin
                if (abort_i) begin
                    w_state_nxt = IDLE;
`ifdef PWM_RAMP_PRESCALE_EN
                    w_pcnt_nxt  = '0;
`endif
                end else if (period_start_i) begin
`ifdef PWM_RAMP_PRESCALE_EN
                    w_pcnt_nxt = w_apply ? 8'd0 : 8'(r_pcnt + 8'd1);
`endif
                    if (w_apply) begin
                        w_cmp_nxt = w_stepped;
                        if (w_stepped == r_target) begin
                            w_state_nxt = IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers: compare output, latched request, done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp    <= LP_RESET_CMP;
            r_target <= '0;
            r_step   <= '0;
            r_done   <= 1'b0;
        end else begin
            r_cmp    <= w_cmp_nxt;
            r_target <= w_target_nxt;
            r_step   <= w_step_nxt;
            r_done   <= w_done_nxt;
        end
    end

`ifdef PWM_RAMP_PRESCALE_EN
    // Strobe counter for the prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= w_pcnt_nxt;
        end
    end
`endif

    assign cmp_value_o = r_cmp;
    assign done_o      = r_done;
    assign cfg_ready_o = (r_state == IDLE);
    assign busy_o      = (r_state == RAMP);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: directed ramp scenarios plus a randomized run against a reference model.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit after the rising edge.
// Build with PWM_RAMP_PRESCALE_EN defined to also exercise the prescaler.
module tb_pwm_ramp_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       period_start_i = 1'b0;
    logic       cfg_valid_i = 1'b0;
    logic       abort_i = 1'b0;
    logic [7:0] cfg_target_i = '0;
    logic [7:0] cfg_step_i = '0;
`ifdef PWM_RAMP_PRESCALE_EN
    logic [7:0] prescale_i = '0;
`endif
    logic       cfg_ready_o;
    logic [7:0] cmp_value_o;
    logic       busy_o;
    logic       done_o;

    always #5 clk = ~clk;

    pwm_ramp_ctrl #(.COUNTER_WIDTH(8), .RESET_CMP(0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .period_start_i (period_start_i),
        .cfg_valid_i    (cfg_valid_i),
        .cfg_ready_o    (cfg_ready_o),
        .cfg_target_i   (cfg_target_i),
        .cfg_step_i     (cfg_step_i),
        .abort_i        (abort_i),
`ifdef PWM_RAMP_PRESCALE_EN
        .prescale_i     (prescale_i),
`endif
        .cmp_value_o    (cmp_value_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [7:0] m_cmp;
    logic [7:0] m_target;
    int         m_step;
    bit         m_busy;
    bit         m_done;
    int         m_pcnt;

    // Move cur toward tgt by at most stp, using signed integer distance.
    function automatic logic [7:0] approach(input logic [7:0] cur, input logic [7:0] tgt, input int stp);
        int c, t, d, ad;
        c  = int'(cur);
        t  = int'(tgt);
        d  = t - c;
        ad = (d < 0) ? -d : d;
        if (ad <= stp) return tgt;
        return (d > 0) ? 8'(c + stp) : 8'(c - stp);
    endfunction

    function automatic int cur_prescale();
`ifdef PWM_RAMP_PRESCALE_EN
        return int'(prescale_i);
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_cmp    = 8'h00;
        m_target = 8'h00;
        m_step   = 0;
        m_busy   = 0;
        m_done   = 0;
        m_pcnt   = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        period_start_i = 1'b0;
        cfg_valid_i    = 1'b0;
        abort_i        = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs, advance the model across the rising edge, settle.
    task automatic cycle(input bit ps, input bit cv, input logic [7:0] tg, input logic [7:0] st, input bit ab);
        @(negedge clk);
        period_start_i = ps;
        cfg_valid_i    = cv;
        cfg_target_i   = tg;
        cfg_step_i     = st;
        abort_i        = ab;
        @(posedge clk);
        m_done = 0;
        if (!m_busy) begin
            if (cv) begin
                m_target = tg;
                m_step   = (st == 8'h00) ? 1 : int'(st);
                m_busy   = 1;
                m_pcnt   = 0;
            end
        end else if (ab) begin
            m_busy = 0;
            m_pcnt = 0;
        end else if (ps) begin
            if (m_pcnt >= cur_prescale()) begin
                m_pcnt = 0;
                m_cmp  = approach(m_cmp, m_target, m_step);
                if (m_cmp == m_target) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end else begin
                m_pcnt++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({cmp_value_o, cfg_ready_o, busy_o, done_o} !== {8'h00, 3'b100}) begin
            n_fail++;
            $display("FAIL reset_init: got cmp=%h rdy=%b busy=%b done=%b, want 00 1 0 0",
                     cmp_value_o, cfg_ready_o, busy_o, done_o);
        end
        cycle(0, 1, 8'h40, 8'h10, 0);
        for (int c = 0; c < 8; c++) cycle(c == 7, 0, 8'h00, 8'h00, 0);
        n_tests++;
        if (cmp_value_o !== 8'h10 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_preramp: got cmp=%h busy=%b, want 10 1", cmp_value_o, busy_o);
        end
        // Assert reset in the middle of the low phase, no clock edge involved.
        @(negedge clk);
        #2;
        rst_n          = 1'b0;
        period_start_i = 1'b0;
        cfg_valid_i    = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if ({cmp_value_o, cfg_ready_o, busy_o, done_o} !== {8'h00, 3'b100}) begin
            n_fail++;
            $display("FAIL reset_async: got cmp=%h rdy=%b busy=%b done=%b, want 00 1 0 0",
                     cmp_value_o, cfg_ready_o, busy_o, done_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 16; c++) begin
                cycle(c == 15, 0, 8'h00, 8'h00, 0);
                n_tests++;
                if ({cmp_value_o, cfg_ready_o, busy_o, done_o} !== {8'h00, 3'b100}) begin
                    n_fail++;
                    $display("FAIL reset_stable p%0d c%0d: got cmp=%h rdy=%b busy=%b done=%b, want 00 1 0 0",
                             k, c, cmp_value_o, cfg_ready_o, busy_o, done_o);
                end
            end
        end
    endtask

    task automatic test_ramp_up();
        logic [7:0] exp_v [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
        cycle(0, 1, 8'h40, 8'h10, 0);
        n_tests++;
        if ({cmp_value_o, cfg_ready_o, busy_o, done_o} !== {8'h00, 3'b010}) begin
            n_fail++;
            $display("FAIL up_accept: got cmp=%h rdy=%b busy=%b done=%b, want 00 0 1 0",
                     cmp_value_o, cfg_ready_o, busy_o, done_o);
        end
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 8; c++) begin
                cycle(c == 7, 0, 8'h00, 8'h00, 0);
                n_tests++;
                if (cmp_value_o !== m_cmp || done_o !== m_done) begin
                    n_fail++;
                    $display("FAIL up_model k%0d c%0d: got cmp=%h done=%b, want %h %b",
                             k, c, cmp_value_o, done_o, m_cmp, m_done);
                end
            end
            n_tests++;
            if (cmp_value_o !== exp_v[k] || done_o !== (k == 3)) begin
                n_fail++;
                $display("FAIL up_step%0d: got cmp=%h done=%b, want %h %b",
                         k, cmp_value_o, done_o, exp_v[k], (k == 3));
            end
        end
        cycle(0, 0, 8'h00, 8'h00, 0);
        n_tests++;
        if ({cmp_value_o, cfg_ready_o, busy_o, done_o} !== {8'h40, 3'b100}) begin
            n_fail++;
            $display("FAIL up_after: got cmp=%h rdy=%b busy=%b done=%b, want 40 1 0 0",
                     cmp_value_o, cfg_ready_o, busy_o, done_o);
        end
    endtask

    // Down with saturation, then up to 0xFF without wrap; second request lands in the done cycle.
    task automatic test_ramp_down_saturate();
        logic [7:0] tg [2] = '{8'h05, 8'hFF};
        logic [7:0] st [2] = '{8'h20, 8'h80};
        logic [7:0] ev [2][2] = '{'{8'h20, 8'h05}, '{8'h85, 8'hFF}};
        for (int r = 0; r < 2; r++) begin
            cycle(0, 1, tg[r], st[r], 0);
            n_tests++;
            if (busy_o !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_accept%0d: got busy=%b, want 1", r, busy_o);
            end
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < 8; c++) begin
                    cycle(c == 7, 0, 8'h00, 8'h00, 0);
                    n_tests++;
                    if (cmp_value_o !== m_cmp || done_o !== m_done) begin
                        n_fail++;
                        $display("FAIL sat_model r%0d k%0d c%0d: got cmp=%h done=%b, want %h %b",
                                 r, k, c, cmp_value_o, done_o, m_cmp, m_done);
                    end
                end
                n_tests++;
                if (cmp_value_o !== ev[r][k] || done_o !== (k == 1)) begin
                    n_fail++;
                    $display("FAIL sat_step r%0d k%0d: got cmp=%h done=%b, want %h %b",
                             r, k, cmp_value_o, done_o, ev[r][k], (k == 1));
                end
            end
        end
    endtask

    task automatic test_step_zero_equal();
        do_reset();
        cycle(0, 1, 8'h03, 8'h00, 0);
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 8; c++) cycle(c == 7, 0, 8'h00, 8'h00, 0);
            n_tests++;
            if (cmp_value_o !== 8'(k + 1) || done_o !== (k == 2)) begin
                n_fail++;
                $display("FAIL step0_%0d: got cmp=%h done=%b, want %h %b",
                         k, cmp_value_o, done_o, 8'(k + 1), (k == 2));
            end
        end
        // Same target again, accepted in the cycle done is high.
        cycle(0, 1, 8'h03, 8'h55, 0);
        n_tests++;
        if (busy_o !== 1'b1 || cmp_value_o !== 8'h03) begin
            n_fail++;
            $display("FAIL equal_accept: got busy=%b cmp=%h, want 1 03", busy_o, cmp_value_o);
        end
        for (int c = 0; c < 8; c++) cycle(c == 7, 0, 8'h00, 8'h00, 0);
        n_tests++;
        if ({cmp_value_o, busy_o, done_o} !== {8'h03, 2'b01}) begin
            n_fail++;
            $display("FAIL equal_done: got cmp=%h busy=%b done=%b, want 03 0 1",
                     cmp_value_o, busy_o, done_o);
        end
    endtask

    task automatic test_abort();
        do_reset();
        cycle(0, 1, 8'h40, 8'h10, 0);
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 8; c++) begin
                cycle(c == 7, (k == 0 && c == 3), 8'h99, 8'h01, 0);
                n_tests++;
                if (cmp_value_o !== m_cmp || busy_o !== m_busy) begin
                    n_fail++;
                    $display("FAIL abort_pre k%0d c%0d: got cmp=%h busy=%b, want %h %b",
                             k, c, cmp_value_o, busy_o, m_cmp, m_busy);
                end
            end
        end
        for (int c = 0; c < 8; c++) cycle(c == 7, 0, 8'h00, 8'h00, c == 7);
        n_tests++;
        if ({cmp_value_o, cfg_ready_o, busy_o, done_o} !== {8'h20, 3'b100}) begin
            n_fail++;
            $display("FAIL abort_hit: got cmp=%h rdy=%b busy=%b done=%b, want 20 1 0 0",
                     cmp_value_o, cfg_ready_o, busy_o, done_o);
        end
        // Abort in IDLE and further strobes change nothing.
        for (int c = 0; c < 8; c++) cycle(c == 7, 0, 8'h00, 8'h00, c == 2);
        n_tests++;
        if ({cmp_value_o, cfg_ready_o, busy_o, done_o} !== {8'h20, 3'b100}) begin
            n_fail++;
            $display("FAIL abort_idle: got cmp=%h rdy=%b busy=%b done=%b, want 20 1 0 0",
                     cmp_value_o, cfg_ready_o, busy_o, done_o);
        end
    endtask

`ifdef PWM_RAMP_PRESCALE_EN
    task automatic test_prescale();
        logic [7:0] ev [6] = '{8'h00, 8'h00, 8'h10, 8'h10, 8'h10, 8'h20};
        do_reset();
        prescale_i = 8'd2;
        cycle(0, 1, 8'h20, 8'h10, 0);
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < 8; c++) cycle(c == 7, 0, 8'h00, 8'h00, 0);
            n_tests++;
            if (cmp_value_o !== ev[k] || done_o !== (k == 5)) begin
                n_fail++;
                $display("FAIL prescale_strobe%0d: got cmp=%h done=%b, want %h %b",
                         k + 1, cmp_value_o, done_o, ev[k], (k == 5));
            end
        end
        prescale_i = 8'd0;
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
`ifdef PWM_RAMP_PRESCALE_EN
            if ($urandom_range(0, 199) == 0) prescale_i = 8'($urandom_range(0, 3));
`endif
            cycle($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, 8'($urandom),
                  ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom), $urandom_range(0, 39) == 0);
            n_tests++;
            if ({cmp_value_o, done_o, busy_o, cfg_ready_o} !== {m_cmp, m_done, m_busy, !m_busy}) begin
                n_fail++;
                $display("FAIL random cyc%0d: got cmp=%h done=%b busy=%b rdy=%b, want %h %b %b %b",
                         i, cmp_value_o, done_o, busy_o, cfg_ready_o, m_cmp, m_done, m_busy, !m_busy);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ramp_up();
        test_ramp_down_saturate();
        test_step_zero_equal();
        test_abort();
`ifdef PWM_RAMP_PRESCALE_EN
        test_prescale();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
